// File: rtl/fifo_param.sv
// fifo_param: synchronous FIFO of DEPTH = 2**ADDR_WIDTH words with
// registered read data, occupancy count/flags and per-operation status.
// Optional build macro FIFO_SIMUL_RW_EN enables a combined read+write
// operation (RDWR) when wr_en and rd_en are both asserted.
module fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [ADDR_WIDTH:0]   data_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    INIT,
    NO_OP,
    WRITE,
    WR_ERR,
    READ,
    RD_ERR
`ifdef FIFO_SIMUL_RW_EN
    , RDWR
`endif
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   head;
  logic [ADDR_WIDTH-1:0]   tail;
  logic                    do_wr;
  logic                    do_rd;

  // Flags come straight from the registered count.
  assign full  = (data_count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty = (data_count == '0);

  // Next-state selection; write requests take priority over reads.
  always_comb begin
    state_nxt = NO_OP;
`ifdef FIFO_SIMUL_RW_EN
    if (wr_en && rd_en) begin
      // Empty: nothing to read, so only the write happens (read flagged).
      state_nxt = empty ? WRITE : RDWR;
    end else
`endif
    if (wr_en && !full)       state_nxt = WRITE;
    else if (wr_en && full)   state_nxt = WR_ERR;
    else if (rd_en && !empty) state_nxt = READ;
    else if (rd_en && empty)  state_nxt = RD_ERR;
  end

`ifdef FIFO_SIMUL_RW_EN
  assign do_wr = (state_nxt == WRITE) || (state_nxt == RDWR);
  assign do_rd = (state_nxt == READ)  || (state_nxt == RDWR);
`else
  assign do_wr = (state_nxt == WRITE);
  assign do_rd = (state_nxt == READ);
`endif

  // State register; status outputs are decoded from it so they appear
  // for exactly the cycle after the operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_nxt;
  end

`ifdef FIFO_SIMUL_RW_EN
  logic rd_err_simul;

  // Remembers a read rejected alongside an accepted write on an empty FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_err_simul <= 1'b0;
    else          rd_err_simul <= wr_en && rd_en && empty;
  end

  assign wr_ack = (state == WRITE) || (state == RDWR);
  assign rd_ack = (state == READ)  || (state == RDWR);
  assign rd_err = (state == RD_ERR) || rd_err_simul;
`else
  assign wr_ack = (state == WRITE);
  assign rd_ack = (state == READ);
  assign rd_err = (state == RD_ERR);
`endif
  assign wr_err = (state == WR_ERR);

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[tail] <= d_in;
  end

  // Pointers, occupancy and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      d_out      <= '0;
    end else begin
      if (do_wr) tail <= tail + ADDR_WIDTH'(1);
      if (do_rd) begin
        head  <= head + ADDR_WIDTH'(1);
        d_out <= mem[head];
      end
      if (do_wr && !do_rd)      data_count <= data_count + (ADDR_WIDTH+1)'(1);
      else if (do_rd && !do_wr) data_count <= data_count - (ADDR_WIDTH+1)'(1);
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (default parameters).
module tb_fifo_param;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] d_in = '0;
  logic [31:0] d_out;
  logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [3:0]  data_count;

  int n_checks = 0;
  int n_fails  = 0;

  fifo_param #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en),
    .d_in(d_in), .d_out(d_out), .full(full), .empty(empty),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err),
    .data_count(data_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic w, input logic r, input logic [31:0] d);
    wr_en = w;
    rd_en = r;
    d_in  = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic wa, input logic we,
                              input logic ra, input logic re);
    check({tag, "_wr_ack"}, 64'(wr_ack), 64'(wa));
    check({tag, "_wr_err"}, 64'(wr_err), 64'(we));
    check({tag, "_rd_ack"}, 64'(rd_ack), 64'(ra));
    check({tag, "_rd_err"}, 64'(rd_err), 64'(re));
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_count", 64'(data_count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full",  64'(full),  64'd0);
    check("rst_dout",  64'(d_out), 64'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Fill: 0x11..0x88
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'h11 * (i + 1));
      check_status($sformatf("fill%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("fill%0d_count", i), 64'(data_count), 64'(i + 1));
    end
    check("fill_full", 64'(full), 64'd1);
    check("fill_empty", 64'(empty), 64'd0);
    check("fill_tail_wrap", 64'(dut.tail), 64'd0);

    // Write while full
    step(1'b1, 1'b0, 32'h99);
    check_status("ovf", 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovf_count", 64'(data_count), 64'd8);
    step(1'b0, 1'b0, 32'h0);
    check_status("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_count", 64'(data_count), 64'd8);

    // Drain: 0x11..0x88 in order
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 32'h0);
      check_status($sformatf("drain%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("drain%0d_dout", i), 64'(d_out), 64'(32'h11 * (i + 1)));
      check($sformatf("drain%0d_count", i), 64'(data_count), 64'(7 - i));
    end
    check("drain_empty", 64'(empty), 64'd1);

    // Read while empty
    step(1'b0, 1'b1, 32'h0);
    check_status("udf", 1'b0, 1'b0, 1'b0, 1'b1);
    check("udf_dout", 64'(d_out), 64'h88);
    check("udf_count", 64'(data_count), 64'd0);

    // Pointer wrap: 5w 5r 6w 6r
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'hA0 + i);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 32'h0);
      check($sformatf("wrapA%0d_dout", i), 64'(d_out), 64'(32'hA0 + i));
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'hB0 + i);
    check("wrap_count6", 64'(data_count), 64'd6);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 32'h0);
      check($sformatf("wrapB%0d_dout", i), 64'(d_out), 64'(32'hB0 + i));
    end
    check("wrap_head", 64'(dut.head), 64'd3);
    check("wrap_tail", 64'(dut.tail), 64'd3);
    check("wrap_count", 64'(data_count), 64'd0);

    // Asynchronous reset between edges with 4 entries held
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'hC0 + i);
    step(1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 32'hC4);
    check("pre_rst_count", 64'(data_count), 64'd4);
    check("pre_rst_dout", 64'(d_out), 64'hC0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_count", 64'(data_count), 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_full",  64'(full),  64'd0);
    check("arst_dout",  64'(d_out), 64'd0);
    check_status("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;

    // First edge after release behaves normally; stale data discarded
    step(1'b0, 1'b1, 32'h0);
    check_status("post_rst", 1'b0, 1'b0, 1'b0, 1'b1);

    // Both enables at count 3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hD0 + i);
    check("both_pre_count", 64'(data_count), 64'd3);
    step(1'b1, 1'b1, 32'h55);
`ifdef FIFO_SIMUL_RW_EN
    check_status("both", 1'b1, 1'b0, 1'b1, 1'b0);
    check("both_count", 64'(data_count), 64'd3);
    check("both_dout", 64'(d_out), 64'hD0);
`else
    check_status("both", 1'b1, 1'b0, 1'b0, 1'b0);
    check("both_count", 64'(data_count), 64'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: pointer width; DEPTH = 2**ADDR_WIDTH entries (8 by default).
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port wr_en, input, 1: write request for the current cycle.
REQ-006 SHALL have port rd_en, input, 1: read request for the current cycle.
REQ-007 SHALL have port d_in, input, DATA_WIDTH: write data, sampled at the edge that accepts a write.
REQ-008 SHALL have port d_out, output, DATA_WIDTH: registered read data.
REQ-009 SHALL have ports full and empty, output, 1 each: occupancy flags.
REQ-010 SHALL have ports wr_ack, wr_err, rd_ack and rd_err, output, 1 each: registered per-operation status.
REQ-011 SHALL have port data_count, output, ADDR_WIDTH+1: current occupancy, 0..DEPTH.

Function
REQ-012 SHALL hold DEPTH x DATA_WIDTH storage, a head (read) pointer and a tail (write) pointer, each ADDR_WIDTH bits, wrapping modulo DEPTH.
REQ-013 SHALL use a registered state with states INIT, NO_OP, WRITE, WR_ERR, READ and RD_ERR, plus RDWR when REQ-024 applies.
REQ-014 SHALL select the next state each edge from wr_en, rd_en and the pre-edge data_count, with the following priority:
- wr_en && !full: WRITE
- wr_en && full: WR_ERR
- rd_en && !empty: READ
- rd_en && empty: RD_ERR
- otherwise: NO_OP
REQ-015 WRITE edge SHALL store d_in at mem[tail], advance tail by 1 (DEPTH-1 wraps to 0) and increment data_count.
REQ-016 READ edge SHALL load d_out from mem[head], advance head by 1 with wrap, and decrement data_count.
REQ-017 WR_ERR, RD_ERR and NO_OP edges SHALL leave storage, pointers, data_count and d_out unchanged.
REQ-018 wr_ack/rd_ack SHALL be 1 for exactly the cycle after an accepted write/read; wr_err/rd_err SHALL be 1 for exactly the cycle after a rejected write/read; all four SHALL be otherwise 0, and at most one SHALL be 1 in any cycle without REQ-024.
REQ-019 full SHALL equal (data_count == DEPTH) and empty SHALL equal (data_count == 0), both combinational from the registered count.
REQ-020 Back-to-back operations SHALL sustain one accepted operation per clock with zero idle cycles.
REQ-021 data_count SHALL never exceed DEPTH or drop below 0 under any input sequence.

Reset
REQ-022 While reset_n == 0, asynchronously and independent of clk, the block SHALL force:
- state = INIT
- head = tail = 0, data_count = 0
- d_out = 0
- all ack/err = 0
- resulting flags: empty = 1, full = 0
REQ-023 Reset asserted mid-operation SHALL discard all stored data; storage contents need not be cleared; the first edge after release SHALL evaluate REQ-014 normally.

Configuration
REQ-024 With macro FIFO_SIMUL_RW_EN defined, wr_en && rd_en SHALL behave as follows:
- when neither full nor empty: enter RDWR; write and read in the same edge, both pointers advance, data_count unchanged, wr_ack and rd_ack both 1 next cycle.
- when full: enter RDWR; d_out = oldest word, d_in is stored into the freed slot, count stays DEPTH.
- when empty: perform WRITE only and assert rd_err.
Without the macro, REQ-014 priority applies: the write (or WR_ERR) wins and the read request is ignored with no rd_err.

Verification
REQ-025 Reset, then 8 writes of 0x11..0x88 on consecutive edges -> wr_ack high 8 cycles, data_count 1..8, full=1 after the 8th write, tail wrapped to 0.
REQ-026 While full, 1 write of 0x99 -> wr_err=1 for one cycle, data_count stays 8, a later read returns 0x11.
REQ-027 8 consecutive reads -> d_out 0x11..0x88 in order, rd_ack each cycle, empty=1 after the last; 1 further read -> rd_err=1, d_out holds 0x88.
REQ-028 Pointer wrap: 5 writes, 5 reads, 6 writes, 6 reads -> data in order, head = tail = 3, data_count = 0.
REQ-029 Reset_n pulsed low between clock edges while data_count=4 -> immediate data_count=0, empty=1, d_out=0, flags cleared.
REQ-030 Both enables at data_count=3: with FIFO_SIMUL_RW_EN -> wr_ack=rd_ack=1, count stays 3; without it -> wr_ack only, count becomes 4.
